// File: rtl/div_share_arbiter_pkg.sv
// Shared definitions for the divider sequencer/arbiter: FSM state encodings,
// default widths and the quotient reported for a zero divisor.
package div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_WIDTH       = 16;
    localparam int DEF_DIV_LATENCY = 1;

    // Quotient returned for a zero divisor; sliced down to the operand width.
    localparam int                   ZDIV_MAX_W = 64;
    localparam logic [ZDIV_MAX_W-1:0] ZDIV_Q_ALL = {ZDIV_MAX_W{1'b1}};

endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester-side bundle of the shared divider arbiter. The arbiter is the
// slave; the requesters (or a bench acting for them) use the master modport.
interface div_share_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_n;
    logic [NUM_REQ*WIDTH-1:0] req_d;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         rsp_q;
    logic [WIDTH-1:0]         rsp_r;
    logic                     rsp_err;
    logic                     busy;

    modport master (
        output req, req_n, req_d,
        input  ack, rsp_q, rsp_r, rsp_err, busy
    );

    modport slave (
        input  req, req_n, req_d,
        output ack, rsp_q, rsp_r, rsp_err, busy
    );
endinterface

// File: rtl/div_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the pointer
// and wraps modulo NUM_REQ. Kept generic so other shared units can reuse it.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    // Walk the requesters in priority order; the first hit wins
    always_comb begin
        int               cand_s;
        logic [IDX_W-1:0] cand_idx_s;
        logic             hit_s;
        grant_valid = 1'b0;
        grant_idx   = {IDX_W{1'b0}};
        cand_s      = 0;
        cand_idx_s  = {IDX_W{1'b0}};
        hit_s       = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s      = int'(pointer) + i;
            cand_s      = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
            cand_idx_s  = cand_s[IDX_W-1:0];
            hit_s       = req[cand_idx_s] && !grant_valid;
            grant_idx   = hit_s ? cand_idx_s : grant_idx;
            grant_valid = grant_valid | req[cand_idx_s];
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Sequencer/arbiter for the single shared N/D -> Q/R divider. Grants the
// divider round-robin, issues registered operands, waits DIV_LATENCY cycles,
// captures Q/R and returns them with a one-cycle one-hot ack.
// Optional feature macro: DIV_ARB_ZERO_CHECK_EN (zero divisor short-circuits
// the divider and reports rsp_err).
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    div_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]  div_N,
    output logic [WIDTH-1:0]  div_D,
    input  logic [WIDTH-1:0]  div_Q,
    input  logic [WIDTH-1:0]  div_R
);

    localparam int                 IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 CNT_W     = $clog2(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e             state_r;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] ack_r;
    logic [WIDTH-1:0]   rsp_quo_r;
    logic [WIDTH-1:0]   rsp_rem_r;
    logic               rsp_err_r;
    logic               busy_r;
    logic [WIDTH-1:0]   div_n_r;
    logic [WIDTH-1:0]   div_d_r;

    logic [NUM_REQ-1:0] req_live_s;
    logic               grant_valid_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [WIDTH-1:0]   win_n_s;
    logic [WIDTH-1:0]   win_d_s;

    // A requester whose ack is on the wire this cycle is still clearing its
    // request, so it is not eligible for the IDLE sample of that same cycle.
    assign req_live_s = bus.req & ~ack_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req_live_s),
        .pointer     (ptr_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Pick the winning requester's dividend and divisor off the packed buses
    always_comb begin
        win_n_s = {WIDTH{1'b0}};
        win_d_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            win_n_s = (grant_idx_s == IDX_W'(i)) ? bus.req_n[i*WIDTH +: WIDTH] : win_n_s;
            win_d_s = (grant_idx_s == IDX_W'(i)) ? bus.req_d[i*WIDTH +: WIDTH] : win_d_s;
        end
    end

    // Sequencer FSM: grant, wait out the divider latency, respond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= {IDX_W{1'b0}};
            ptr_r     <= IDX_W'(NUM_REQ - 1);
            cnt_r     <= {CNT_W{1'b0}};
            ack_r     <= {NUM_REQ{1'b0}};
            rsp_quo_r <= {WIDTH{1'b0}};
            rsp_rem_r <= {WIDTH{1'b0}};
            rsp_err_r <= 1'b0;
            busy_r    <= 1'b0;
            div_n_r   <= {WIDTH{1'b0}};
            div_d_r   <= {WIDTH{1'b0}};
        end else begin
            ack_r <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        grant_r <= grant_idx_s;
                        busy_r  <= 1'b1;
`ifdef DIV_ARB_ZERO_CHECK_EN
                        if (win_d_s == {WIDTH{1'b0}}) begin
                            rsp_quo_r <= ZDIV_Q_ALL[WIDTH-1:0];
                            rsp_rem_r <= win_n_s;
                            rsp_err_r <= 1'b1;
                            state_r   <= ST_RESP;
                        end else begin
                            div_n_r <= win_n_s;
                            div_d_r <= win_d_s;
                            cnt_r   <= CNT_LOAD;
                            state_r <= ST_WAIT;
                        end
`else
                        div_n_r <= win_n_s;
                        div_d_r <= win_d_s;
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_WAIT;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        rsp_quo_r <= div_Q;
                        rsp_rem_r <= div_R;
                        rsp_err_r <= 1'b0;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    ack_r   <= ONE_HOT_0 << grant_r;
                    ptr_r   <= grant_r;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = ack_r;
    assign bus.rsp_q   = rsp_quo_r;
    assign bus.rsp_r   = rsp_rem_r;
    assign bus.rsp_err = rsp_err_r;
    assign bus.busy    = busy_r;
    assign div_N       = div_n_r;
    assign div_D       = div_d_r;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter: one instance with a combinational
// divider (DIV_LATENCY=1) and one with a two-register divider (DIV_LATENCY=3).
module tb_div_share_arbiter;

`ifdef DIV_ARB_ZERO_CHECK_EN
    localparam int   ZC_LAT  = 1;
    localparam logic ZC_ERR  = 1'b1;
    localparam bit   ZC_KEEP = 1'b1;
`else
    localparam int   ZC_LAT  = 2;
    localparam logic ZC_ERR  = 1'b0;
    localparam bit   ZC_KEEP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst3_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    div_share_arbiter_if #(.NUM_REQ(2), .WIDTH(16)) bus1 ();
    div_share_arbiter_if #(.NUM_REQ(2), .WIDTH(16)) bus3 ();

    logic [15:0] d1_N, d1_D, d1_Q, d1_R;
    logic [15:0] d3_N, d3_D, d3_Q, d3_R;
    logic [31:0] p1_r = 32'd0;
    logic [31:0] p2_r = 32'd0;

    div_share_arbiter #(.NUM_REQ(2), .WIDTH(16), .DIV_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1),
        .div_N(d1_N), .div_D(d1_D), .div_Q(d1_Q), .div_R(d1_R)
    );

    div_share_arbiter #(.NUM_REQ(2), .WIDTH(16), .DIV_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(bus3),
        .div_N(d3_N), .div_D(d3_D), .div_Q(d3_Q), .div_R(d3_R)
    );

    // Divider model: zero divisor yields all-ones quotient and the dividend
    function automatic logic [31:0] div_model(input logic [15:0] n, input logic [15:0] d);
        if (d == 16'd0) return {16'hFFFF, n};
        return {n / d, n % d};
    endfunction

    always_comb {d1_Q, d1_R} = div_model(d1_N, d1_D);

    always @(posedge clk) begin
        p1_r <= div_model(d3_N, d3_D);
        p2_r <= p1_r;
    end
    assign {d3_Q, d3_R} = p2_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_req(input int sel, input int idx, input logic v,
                           input logic [15:0] n, input logic [15:0] d);
        if (sel == 1) begin
            bus1.req[idx[0]] = v;
            if (idx == 0) begin bus1.req_n[15:0]  = n; bus1.req_d[15:0]  = d; end
            else          begin bus1.req_n[31:16] = n; bus1.req_d[31:16] = d; end
        end else begin
            bus3.req[idx[0]] = v;
            if (idx == 0) begin bus3.req_n[15:0]  = n; bus3.req_d[15:0]  = d; end
            else          begin bus3.req_n[31:16] = n; bus3.req_d[31:16] = d; end
        end
    endtask

    function automatic logic [1:0]  get_ack(input int sel);  return (sel == 1) ? bus1.ack     : bus3.ack;     endfunction
    function automatic logic        get_busy(input int sel); return (sel == 1) ? bus1.busy    : bus3.busy;    endfunction
    function automatic logic [15:0] get_q(input int sel);    return (sel == 1) ? bus1.rsp_q   : bus3.rsp_q;   endfunction
    function automatic logic [15:0] get_r(input int sel);    return (sel == 1) ? bus1.rsp_r   : bus3.rsp_r;   endfunction
    function automatic logic        get_err(input int sel);  return (sel == 1) ? bus1.rsp_err : bus3.rsp_err; endfunction

    // One isolated operation; called #1 after a posedge with the DUT in IDLE
    task automatic do_op(input int sel, input int idx, input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] q, input logic [15:0] r, input logic err,
                         input int lat, input string name);
        int         edges;
        int         busy_c;
        logic       got;
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        set_req(sel, idx, 1'b1, n, d);
        edges = 0; busy_c = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            edges++;
            if (get_ack(sel) != 2'b00) got = 1'b1;
            else if (get_busy(sel)) busy_c++;
        end
        check({name, "_ack_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, edges - 1, lat);
        check({name, "_busy_cycles"}, busy_c, lat);
        check({name, "_busy_at_ack"}, 32'(get_busy(sel)), 32'd0);
        check({name, "_ack_vec"}, 32'(get_ack(sel)), 32'(oh));
        check({name, "_q"}, 32'(get_q(sel)), 32'(q));
        check({name, "_r"}, 32'(get_r(sel)), 32'(r));
        check({name, "_err"}, 32'(get_err(sel)), 32'(err));
        set_req(sel, idx, 1'b0, n, d);
        @(posedge clk); #1;
        check({name, "_ack_pulse"}, 32'(get_ack(sel)), 32'd0);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int start, t0, t1, overlap, nack, last, g, noack;

        vecs[0] = '{0, 16'd100,   16'd3,     16'd33,    16'd1};
        vecs[1] = '{1, 16'd65535, 16'd1,     16'd65535, 16'd0};
        vecs[2] = '{0, 16'd5,     16'd9,     16'd0,     16'd5};
        vecs[3] = '{1, 16'd12345, 16'd123,   16'd100,   16'd45};
        vecs[4] = '{0, 16'd0,     16'd7,     16'd0,     16'd0};
        vecs[5] = '{1, 16'd65535, 16'd65535, 16'd1,     16'd0};

        rst1_n = 1'b0; rst3_n = 1'b0;
        bus1.req = 2'b00; bus1.req_n = 32'd0; bus1.req_d = 32'd0;
        bus3.req = 2'b00; bus3.req_n = 32'd0; bus3.req_d = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst1_n = 1'b1; rst3_n = 1'b1;

        // Reset state
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_ack", 32'(bus1.ack), 32'd0);
        check("rst_q", 32'(bus1.rsp_q), 32'd0);
        check("rst_r", 32'(bus1.rsp_r), 32'd0);
        check("rst_err", 32'(bus1.rsp_err), 32'd0);
        check("rst_divN", 32'(d1_N), 32'd0);
        check("rst_divD", 32'(d1_D), 32'd0);
        check("rst3_ack", 32'(bus3.ack), 32'd0);

        // Simultaneous requests right after reset: requester 0 first
        set_req(1, 0, 1'b1, 16'd7, 16'd2);
        set_req(1, 1, 1'b1, 16'd9, 16'd4);
        start = cyc; t0 = -1; t1 = -1; overlap = 0;
        for (int c = 0; c < 20 && (t0 < 0 || t1 < 0); c++) begin
            @(posedge clk); #1;
            if (bus1.ack == 2'b11) overlap++;
            if (bus1.ack[0]) begin
                t0 = cyc;
                check("sim_q0", 32'(bus1.rsp_q), 32'd3);
                check("sim_r0", 32'(bus1.rsp_r), 32'd1);
                set_req(1, 0, 1'b0, 16'd7, 16'd2);
            end
            if (bus1.ack[1]) begin
                t1 = cyc;
                check("sim_q1", 32'(bus1.rsp_q), 32'd2);
                check("sim_r1", 32'(bus1.rsp_r), 32'd1);
                set_req(1, 1, 1'b0, 16'd9, 16'd4);
            end
        end
        check("sim_first_lat", t0 - start, 3);
        check("sim_spacing", t1 - t0, 3);
        check("sim_overlap", overlap, 0);
        @(posedge clk); #1;

        // Continuous requests from both: grants alternate 0,1,0,1,0,1
        set_req(1, 0, 1'b1, 16'd50, 16'd7);
        set_req(1, 1, 1'b1, 16'd1000, 16'd33);
        nack = 0; last = -1; overlap = 0;
        for (int c = 0; c < 60 && nack < 6; c++) begin
            @(posedge clk); #1;
            if (bus1.ack == 2'b11) overlap++;
            if (bus1.ack != 2'b00) begin
                g = bus1.ack[1] ? 1 : 0;
                check($sformatf("cont_grant%0d", nack), g, nack % 2);
                check($sformatf("cont_q%0d", nack), 32'(bus1.rsp_q), (g == 0) ? 32'd7 : 32'd30);
                check($sformatf("cont_r%0d", nack), 32'(bus1.rsp_r), (g == 0) ? 32'd1 : 32'd10);
                if (last >= 0) check($sformatf("cont_spacing%0d", nack), cyc - last, 3);
                last = cyc;
                nack++;
            end
        end
        set_req(1, 0, 1'b0, 16'd50, 16'd7);
        set_req(1, 1, 1'b0, 16'd1000, 16'd33);
        check("cont_count", nack, 6);
        check("cont_overlap", overlap, 0);
        @(posedge clk); #1;
        check("cont_idle", 32'(bus1.busy), 32'd0);

        // Table of single operations on the combinational-divider instance
        for (int i = 0; i < 6; i++) begin
            do_op(1, vecs[i].idx, vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r,
                  1'b0, 2, $sformatf("vec%0d", i));
        end

        // Zero divisor
        do_op(1, 0, 16'd42, 16'd0, 16'hFFFF, 16'd42, ZC_ERR, ZC_LAT, "zero");
        check("zero_divD", 32'(d1_D), ZC_KEEP ? 32'(vecs[5].d) : 32'd0);
        check("zero_divN", 32'(d1_N), ZC_KEEP ? 32'(vecs[5].n) : 32'd42);

        // Three-cycle divider
        do_op(3, 0, 16'd65535, 16'd10, 16'd6553, 16'd5, 1'b0, 4, "lat3");

        // Reset while in WAIT: result discarded, no ack, then a clean retry
        set_req(3, 0, 1'b1, 16'd100, 16'd7);
        @(posedge clk); #1;
        check("mid_busy_before", 32'(bus3.busy), 32'd1);
        rst3_n = 1'b0;
        set_req(3, 0, 1'b0, 16'd100, 16'd7);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        check("mid_busy", 32'(bus3.busy), 32'd0);
        check("mid_ack", 32'(bus3.ack), 32'd0);
        check("mid_q", 32'(bus3.rsp_q), 32'd0);
        check("mid_r", 32'(bus3.rsp_r), 32'd0);
        check("mid_err", 32'(bus3.rsp_err), 32'd0);
        check("mid_divN", 32'(d3_N), 32'd0);
        check("mid_divD", 32'(d3_D), 32'd0);
        noack = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus3.ack != 2'b00) noack++;
        end
        check("mid_no_ack", noack, 0);
        do_op(3, 0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 4, "mid_retry");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
